// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch PC generator.
//   br_op_e   : D-stage control-transfer op codes (unused codes act as PC4)
//   npc_sel_e : next-PC source selector used by the priority mux
//   PC_RESET_DEF / EXC_ENTRY_DEF : default boot and exception-handler addresses
package pc_gen_pkg;

    typedef enum logic [3:0] {
        BR_PC4   = 4'd0,
        BR_J     = 4'd1,
        BR_JR    = 4'd2,
        BR_BEQ   = 4'd3,
        BR_BNE   = 4'd4,
        BR_BLEZ  = 4'd5,
        BR_BGTZ  = 4'd6,
        BR_BLTZ  = 4'd7,
        BR_BGEZ  = 4'd8,
        BR_BEQL  = 4'd9,
        BR_BNEL  = 4'd10,
        BR_BLTZL = 4'd11,
        BR_BGEZL = 4'd12
    } br_op_e;

    typedef enum logic [2:0] {
        NPC_PC4    = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_J      = 3'd2,
        NPC_JR     = 3'd3,
        NPC_HOLD   = 3'd4,
        NPC_EPC    = 3'd5,
        NPC_EXC    = 3'd6
    } npc_sel_e;

    localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;

endpackage

// File: rtl/pc_gen_br_cond.sv
// Branch condition evaluation for the D-stage control-transfer op.
//   br_op    in  : control-transfer op (pc_gen_pkg::br_op_e encoding)
//   rs_eq_rt in  : rs == rt
//   rs_ltz   in  : rs < 0
//   rs_eqz   in  : rs == 0
//   taken    out : conditional branch condition holds (0 for jumps and PC4)
//   likely   out : op is a branch-likely variant
module br_cond
    import pc_gen_pkg::*;
(
    input  logic [3:0] br_op,
    input  logic       rs_eq_rt,
    input  logic       rs_ltz,
    input  logic       rs_eqz,
    output logic       taken,
    output logic       likely
);

    always_comb begin
        taken  = 1'b0;
        likely = 1'b0;
        case (br_op)
            BR_BEQ:   taken = rs_eq_rt;
            BR_BNE:   taken = !rs_eq_rt;
            BR_BLEZ:  taken = rs_ltz | rs_eqz;
            BR_BGTZ:  taken = !(rs_ltz | rs_eqz);
            BR_BLTZ:  taken = rs_ltz;
            BR_BGEZ:  taken = !rs_ltz;
            BR_BEQL:  begin taken = rs_eq_rt;  likely = 1'b1; end
            BR_BNEL:  begin taken = !rs_eq_rt; likely = 1'b1; end
            BR_BLTZL: begin taken = rs_ltz;    likely = 1'b1; end
            BR_BGEZL: begin taken = !rs_ltz;   likely = 1'b1; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: holds the fetch PC and picks the next one from
// exception entry, eret return, stall hold, jump/branch target or PC+4.
//   clk, reset(active-low async)
//   stall, req, eret, epc            : pipeline control / redirects
//   br_op, rs_eq_rt, rs_ltz, rs_eqz  : D-stage control transfer and compare flags
//   imm26, ext, rd1                  : jump index, sign-extended offset, forwarded rs
//   pc_F    out : registered fetch PC (already D-instruction PC + 4)
//   flush_D out : annul the instruction being fetched
//   bd_F    out : fetched instruction is a delay slot
//   adel_F  out : fetch address misaligned or outside the text window
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
    parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI   = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic [3:0]  br_op,
    input  logic        rs_eq_rt,
    input  logic        rs_ltz,
    input  logic        rs_eqz,
    input  logic [25:0] imm26,
    input  logic [31:0] ext,
    input  logic [31:0] rd1,
    output logic [31:0] pc_F,
    output logic        flush_D,
    output logic        bd_F,
    output logic        adel_F
);

    logic        taken;
    logic        likely;
    logic        is_cti;
    npc_sel_e    npc_sel;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    br_cond u_br_cond (
        .br_op    (br_op),
        .rs_eq_rt (rs_eq_rt),
        .rs_ltz   (rs_ltz),
        .rs_eqz   (rs_eqz),
        .taken    (taken),
        .likely   (likely)
    );

    assign pc_plus4  = pc_F + 32'd4;
    assign br_target = pc_F + {ext[29:0], 2'b00};
    assign j_target  = {pc_F[31:28], imm26, 2'b00};

    // Unused op codes fall outside this range and so behave as PC4.
    assign is_cti = (br_op >= BR_J) && (br_op <= BR_BGEZL);

    always_comb begin
        npc_sel = NPC_PC4;
        if (req)
            npc_sel = NPC_EXC;
        else if (eret)
            npc_sel = NPC_EPC;
        else if (stall)
            npc_sel = NPC_HOLD;
        else if (br_op == BR_J)
            npc_sel = NPC_J;
        else if (br_op == BR_JR)
            npc_sel = NPC_JR;
        else if (taken)
            npc_sel = NPC_BRANCH;
    end

    always_comb begin
        next_pc = pc_plus4;
        case (npc_sel)
            NPC_EXC:    next_pc = EXC_ENTRY;
            NPC_EPC:    next_pc = epc;
            NPC_HOLD:   next_pc = pc_F;
            NPC_J:      next_pc = j_target;
            NPC_JR:     next_pc = rd1;
            NPC_BRANCH: next_pc = br_target;
            default:    next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc_F <= PC_RESET;
        else
            pc_F <= next_pc;
    end

    // Status outputs are gated by reset so inputs are ignored while it is held.
    assign flush_D = reset && !req && (eret || (likely && !taken && !stall));
    assign bd_F    = reset && is_cti && !stall && !req && !eret;
    assign adel_F  = reset && ((pc_F[1:0] != 2'b00) || (pc_F < TEXT_LO) || (pc_F > TEXT_HI));

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic [3:0]  br_op;
    logic        rs_eq_rt;
    logic        rs_ltz;
    logic        rs_eqz;
    logic [25:0] imm26;
    logic [31:0] ext;
    logic [31:0] rd1;
    logic [31:0] pc_F;
    logic        flush_D;
    logic        bd_F;
    logic        adel_F;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_pc;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .epc(epc),
        .br_op(br_op), .rs_eq_rt(rs_eq_rt), .rs_ltz(rs_ltz), .rs_eqz(rs_eqz),
        .imm26(imm26), .ext(ext), .rd1(rd1),
        .pc_F(pc_F), .flush_D(flush_D), .bd_F(bd_F), .adel_F(adel_F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (instruction-set level) ----------------
    // Op numbers: 0 PC4, 1 J, 2 JR, 3 BEQ, 4 BNE, 5 BLEZ, 6 BGTZ, 7 BLTZ,
    // 8 BGEZ, 9 BEQL, 10 BNEL, 11 BLTZL, 12 BGEZL; anything else is PC4.
    function automatic bit m_is_branch(int op);
        return op >= 3 && op <= 12;
    endfunction

    function automatic bit m_is_likely(int op);
        return op >= 9 && op <= 12;
    endfunction

    function automatic bit m_taken(int op, bit eq, bit ltz, bit eqz);
        int base;
        base = (op >= 9) ? ((op == 9) ? 3 : (op == 10) ? 4 : (op == 11) ? 7 : 8) : op;
        case (base)
            3: return eq;
            4: return !eq;
            5: return ltz || eqz;
            6: return !(ltz || eqz);
            7: return ltz;
            8: return !ltz;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_next(logic [31:0] pc);
        int op;
        longint unsigned t;
        op = int'(br_op);
        if (!reset) return 32'h3000;
        if (req) return 32'h4180;
        if (eret) return epc;
        if (stall) return pc;
        if (op == 1) return (pc & 32'hF000_0000) | (32'(imm26) * 4);
        if (op == 2) return rd1;
        if (m_is_branch(op) && m_taken(op, rs_eq_rt, rs_ltz, rs_eqz)) begin
            t = longint'(pc) + longint'(ext) * 4;
            return t[31:0];
        end
        return pc + 4;
    endfunction

    function automatic bit m_flush();
        int op;
        op = int'(br_op);
        if (!reset || req) return 1'b0;
        if (eret) return 1'b1;
        return m_is_likely(op) && !stall && !m_taken(op, rs_eq_rt, rs_ltz, rs_eqz);
    endfunction

    function automatic bit m_bd();
        int op;
        op = int'(br_op);
        return reset && (op >= 1 && op <= 12) && !stall && !req && !eret;
    endfunction

    function automatic bit m_adel(logic [31:0] pc);
        return reset && ((pc % 4) != 0 || pc < 32'h3000 || pc > 32'h6FFC);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        stall = 0; req = 0; eret = 0; epc = 0; br_op = BR_PC4;
        rs_eq_rt = 0; rs_ltz = 0; rs_eqz = 0; imm26 = 0; ext = 0; rd1 = 0;
    endtask

    // Called at posedge+1 with inputs already driven: checks combinational
    // outputs, clocks one edge, then checks the new fetch PC.
    task automatic cycle(string name);
        logic [31:0] exp_pc;
        bit ef, eb, ea;
        #1;
        ef = m_flush(); eb = m_bd(); ea = m_adel(model_pc);
        exp_pc = m_next(model_pc);
        checks++;
        if (flush_D !== ef) begin
            errors++;
            $display("FAIL %s flush_D: got %b want %b (pc %h)", name, flush_D, ef, model_pc);
        end
        checks++;
        if (bd_F !== eb) begin
            errors++;
            $display("FAIL %s bd_F: got %b want %b (pc %h)", name, bd_F, eb, model_pc);
        end
        checks++;
        if (adel_F !== ea) begin
            errors++;
            $display("FAIL %s adel_F: got %b want %b (pc %h)", name, adel_F, ea, model_pc);
        end
        @(posedge clk);
        #1;
        model_pc = exp_pc;
        checks++;
        if (pc_F !== exp_pc) begin
            errors++;
            $display("FAIL %s pc_F: got %h want %h", name, pc_F, exp_pc);
        end
    endtask

    task automatic set_pc(logic [31:0] target);
        idle_inputs();
        br_op = BR_JR; rd1 = target;
        cycle("set_pc");
        idle_inputs();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 0;
        idle_inputs();
        br_op = BR_J; req = 1; eret = 1; epc = 32'h5000; imm26 = 26'h3FFFFFF;
        model_pc = 32'h3000;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (pc_F !== 32'h3000 || adel_F !== 0 || flush_D !== 0 || bd_F !== 0) begin
                errors++;
                $display("FAIL reset_hold: got pc %h adel %b flush %b bd %b want 3000 0 0 0",
                         pc_F, adel_F, flush_D, bd_F);
            end
        end
        idle_inputs();
        reset = 1;
        cycle("reset_step1");
        checks++;
        if (pc_F !== 32'h3004) begin
            errors++;
            $display("FAIL reset_step1_abs: got %h want 00003004", pc_F);
        end
        cycle("reset_step2");
        checks++;
        if (pc_F !== 32'h3008) begin
            errors++;
            $display("FAIL reset_step2_abs: got %h want 00003008", pc_F);
        end
    endtask

    task automatic test_branch();
        idle_inputs();
        br_op = BR_BEQ; rs_eq_rt = 1; ext = 32'hFFFF_FFFE;
        cycle("beq_taken");
        checks++;
        if (pc_F !== 32'h3000) begin
            errors++;
            $display("FAIL beq_taken_abs: got %h want 00003000", pc_F);
        end
        set_pc(32'h3008);
        br_op = BR_BEQ; rs_eq_rt = 0; ext = 32'hFFFF_FFFE;
        cycle("beq_not_taken");
        checks++;
        if (pc_F !== 32'h300C) begin
            errors++;
            $display("FAIL beq_not_taken_abs: got %h want 0000300c", pc_F);
        end
    endtask

    task automatic test_likely();
        set_pc(32'h3010);
        br_op = BR_BGEZL; rs_ltz = 1;
        cycle("likely_not_taken");
        set_pc(32'h3010);
        br_op = BR_BGEZL; rs_ltz = 1; stall = 1;
        cycle("likely_stalled");
        checks++;
        if (pc_F !== 32'h3010) begin
            errors++;
            $display("FAIL likely_stalled_abs: got %h want 00003010", pc_F);
        end
        stall = 0;
        cycle("likely_after_stall");
        br_op = BR_BNEL; rs_eq_rt = 0; ext = 32'd4;
        cycle("likely_taken");
    endtask

    task automatic test_priority();
        idle_inputs();
        stall = 1; eret = 1; epc = 32'h3020; br_op = BR_BEQ; rs_eq_rt = 1; ext = 32'd8;
        cycle("eret_over_stall");
        checks++;
        if (pc_F !== 32'h3020) begin
            errors++;
            $display("FAIL eret_over_stall_abs: got %h want 00003020", pc_F);
        end
        req = 1;
        cycle("req_over_all");
        checks++;
        if (pc_F !== 32'h4180) begin
            errors++;
            $display("FAIL req_over_all_abs: got %h want 00004180", pc_F);
        end
        idle_inputs();
        req = 1; br_op = BR_BEQL; rs_eq_rt = 1; ext = 32'd16;
        cycle("req_with_taken");
        idle_inputs();
    endtask

    task automatic test_jumps();
        set_pc(32'h3000);
        br_op = BR_J; imm26 = 26'h0000C05;
        cycle("jump_j");
        checks++;
        if (pc_F !== 32'h3014) begin
            errors++;
            $display("FAIL jump_j_abs: got %h want 00003014", pc_F);
        end
        idle_inputs();
        br_op = BR_JR; rd1 = 32'h3002;
        cycle("jr_misaligned");
        idle_inputs();
        stall = 1;
        cycle("adel_misaligned");
        idle_inputs();
        br_op = BR_JR; rd1 = 32'h7000;
        cycle("jr_above_text");
        idle_inputs();
        br_op = 4'd14;
        cycle("unused_op");
        br_op = BR_JR; rd1 = 32'h6FFC;
        cycle("jr_text_hi");
        idle_inputs();
        stall = 1;
        cycle("adel_text_hi");
        idle_inputs();
    endtask

    task automatic test_async_reset();
        set_pc(32'h3100);
        stall = 1;
        #2;
        reset = 0;
        #1;
        model_pc = 32'h3000;
        checks++;
        if (pc_F !== 32'h3000 || flush_D !== 0 || bd_F !== 0 || adel_F !== 0) begin
            errors++;
            $display("FAIL async_reset: got pc %h flush %b bd %b adel %b want 3000 0 0 0",
                     pc_F, flush_D, bd_F, adel_F);
        end
        @(posedge clk); #1;
        eret = 1; epc = 32'h3300;
        cycle("reset_held");
        idle_inputs();
        reset = 1;
        cycle("after_reset_release");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall    = ($urandom_range(0, 3) == 0);
            req      = ($urandom_range(0, 15) == 0);
            eret     = ($urandom_range(0, 15) == 0);
            epc      = 32'h3000 + 4 * $urandom_range(0, 4095);
            br_op    = 4'($urandom_range(0, 15));
            rs_eq_rt = 1'($urandom);
            rs_ltz   = 1'($urandom);
            rs_eqz   = 1'($urandom);
            imm26    = 26'($urandom);
            ext      = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64))
                                                   : -32'($urandom_range(0, 64));
            rd1      = ($urandom_range(0, 7) == 0) ? $urandom
                                                   : 32'h3000 + 4 * $urandom_range(0, 4095);
            reset    = ($urandom_range(0, 40) != 0);
            if (!reset) model_pc = 32'h3000;
            cycle("random");
            // keep the PC near the text window so branches stay interesting
            if (model_pc < 32'h3000 || model_pc > 32'h6FFC) begin
                reset = 1;
                set_pc(32'h3000 + 4 * $urandom_range(0, 4095));
            end
        end
        reset = 1;
        idle_inputs();
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        #1;
        test_reset();
        test_branch();
        test_likely();
        test_priority();
        test_jumps();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameters SHALL be: PC_RESET, default 32'h0000_3000, fetch PC after reset; EXC_ENTRY, default 32'h0000_4180, exception handler address; TEXT_LO, default 32'h0000_3000, lowest legal fetch address; TEXT_HI, default 32'h0000_6FFC, highest legal fetch address.
REQ-002 Ports SHALL be: clk in 1, single clock; reset in 1, asynchronous active-low reset; stall in 1, hazard freeze of F/D; req in 1, exception/interrupt redirect; eret in 1, eret decoded in D; epc in 32, return address; br_op in 4, D-stage control-transfer op; rs_eq_rt in 1; rs_ltz in 1, rs<0; rs_eqz in 1, rs==0; imm26 in 26; ext in 32, sign-extended offset; rd1 in 32, forwarded rs; pc_F out 32, fetch PC; flush_D out 1, annul the instruction being fetched; bd_F out 1, fetched instruction is a delay slot; adel_F out 1, fetch address error.

Function
REQ-003 pc_F SHALL be a register updated on every rising clk edge with next_pc; all other outputs SHALL be combinational.
REQ-004 br_op encodings SHALL be: PC4, J, JR, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BEQL, BNEL, BLTZL, BGEZL; unused codes SHALL behave as PC4.
REQ-005 Taken conditions: BEQ/BEQL rs_eq_rt; BNE/BNEL !rs_eq_rt; BLEZ rs_ltz|rs_eqz; BGTZ !(rs_ltz|rs_eqz); BLTZ/BLTZL rs_ltz; BGEZ/BGEZL !rs_ltz.
REQ-006 Targets (pc_F is D-instruction PC + 4): branch = pc_F + (ext<<2), 32-bit wrap; J = {pc_F[31:28], imm26, 2'b00}; JR = rd1 unmodified.
REQ-007 next_pc priority, highest first: req -> EXC_ENTRY; eret -> epc; stall -> pc_F; J/JR/taken branch -> target; otherwise pc_F + 4.
REQ-008 req SHALL override stall and eret in the same cycle; eret SHALL override stall.
REQ-009 flush_D SHALL be 1 when eret=1 and req=0 (eret has no delay slot), or when a likely branch is not taken with stall=0 and req=0; otherwise 0.
REQ-010 When stall=1, flush_D SHALL be 0 and branch evaluation SHALL repeat unchanged on the next unstalled cycle.
REQ-011 bd_F SHALL be 1 when br_op != PC4, stall=0, req=0 and eret=0, independent of taken.
REQ-012 adel_F SHALL be 1 when pc_F[1:0] != 0 or pc_F < TEXT_LO or pc_F > TEXT_HI (unsigned compare); a misaligned JR target SHALL still load into pc_F.
REQ-013 Simultaneous req and taken branch: pc_F SHALL load EXC_ENTRY and flush_D, bd_F SHALL be 0.

Reset
REQ-014 reset=0 SHALL asynchronously force pc_F to PC_RESET, independent of clk.
REQ-015 While reset=0, flush_D, bd_F and adel_F SHALL be 0, and all inputs SHALL be ignored.
REQ-016 On reset deassertion, the first rising edge SHALL apply REQ-007 normally; reset asserted mid-stall SHALL discard the stall.

Structure
REQ-017 The br_op encodings, PC_RESET and EXC_ENTRY defaults SHALL be defined in the shared constants file with the existing npc_* selector macros.
REQ-018 Condition evaluation (REQ-005) SHALL be a sub-module br_cond (br_op and compare flags in; taken and likely out); the PC register and priority mux SHALL stay in pc_gen.

Verification
REQ-019 Reset: hold reset=0 for 3 clk cycles -> pc_F=32'h3000, adel_F=0; release with br_op=PC4 -> pc_F steps 3004, 3008.
REQ-020 Branch: pc_F=3008, BEQ, rs_eq_rt=1, ext=32'hFFFF_FFFE -> next pc_F=3000, bd_F=1, flush_D=0; same with rs_eq_rt=0 -> 300C.
REQ-021 Likely: pc_F=3010, BGEZL, rs_ltz=1 -> flush_D=1, pc_F=3014; repeat with stall=1 -> flush_D=0, pc_F holds 3010.
REQ-022 Priority: stall=1, eret=1, epc=3020 -> pc_F=3020, flush_D=1; add req=1 -> pc_F=4180, flush_D=0.
REQ-023 Jumps/errors: pc_F=3000, J, imm26=26'h0000C05 -> pc_F=3014; JR, rd1=3002 -> pc_F=3002, adel_F=1; JR, rd1=7000 -> adel_F=1.
REQ-024 Async reset: assert reset=0 between clk edges while pc_F=3100 -> pc_F=3000 before the next edge.
